dmem_arbiter: RTL and testbench

- Shares the single data memory between two requesters: port 0 is the core LD/ST path and port 1 is the network/DMA path.
- Arbitrates round-robin and holds the grant until that requester has consumed its response.
- Uses the same valid/yumi handshake the core already uses toward data memory, on both the requester side and the memory side.
- Sits between the core tiles and the data memory in the top level.

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter_rr_pick2.sv | 26 ++
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, the
// arbiter state encoding and a small port-index helper.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_WIDTH = 32;
  localparam int unsigned DMEM_DATA_WIDTH = 32;
  localparam int unsigned DMEM_NUM_PORTS  = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    RETURN    = 2'd3
  } arb_state_e;

  // Port index to one-hot vector over the two requesters.
  function automatic logic [DMEM_NUM_PORTS-1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick. Purely combinational; the caller owns the
// "last granted" history. On contention the port that did not win last
// time is chosen.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       any
);

  // One requester wins outright; two requesters go to the one not granted last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = port_onehot(~last);
      default: gnt = 2'b00;
    endcase
  end

  assign any = |req;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data memory between the core LD/ST path (port 0) and
// the network/DMA path (port 1). One transaction is outstanding at a time;
// the grant is held until the winning requester consumes its response.
// Both sides use a valid/yumi handshake.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no transaction; accept a request and latch its fields
// ISSUE     | latched request presented to memory until mem_req_yumi_i
// WAIT_RESP | request accepted by memory, waiting for mem_resp_valid_i
// RETURN    | response held for grant_r until it returns resp_yumi_i
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned addr_width_p = DMEM_ADDR_WIDTH,
  parameter int unsigned data_width_p = DMEM_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic [1:0]                   req_valid_i,
  input  logic [1:0][addr_width_p-1:0] req_addr_i,
  input  logic [1:0]                   req_wen_i,
  input  logic [1:0]                   req_byte_i,
  input  logic [1:0][data_width_p-1:0] req_wdata_i,
  output logic [1:0]                   req_yumi_o,

  output logic [1:0]                   resp_valid_o,
  output logic [data_width_p-1:0]      resp_data_o,
  input  logic [1:0]                   resp_yumi_i,

  output logic                         mem_valid_o,
  output logic [addr_width_p-1:0]      mem_addr_o,
  output logic                         mem_wen_o,
  output logic                         mem_byte_o,
  output logic [data_width_p-1:0]      mem_wdata_o,
  input  logic                         mem_req_yumi_i,
  input  logic                         mem_resp_valid_i,
  input  logic [data_width_p-1:0]      mem_resp_data_i,
  output logic                         mem_resp_yumi_o,

  output logic                         busy_o
);

  arb_state_e              state_r;
  logic                    grant_r;
  logic                    last_grant_r;
  logic [addr_width_p-1:0] addr_r;
  logic                    wen_r;
  logic                    byte_r;
  logic [data_width_p-1:0] wdata_r;
  logic [data_width_p-1:0] resp_data_r;

  logic [1:0] pick_gnt;
  logic       pick_any;
  logic       pick_idx;
  logic       mem_resp_take;

  rr_pick2 u_pick (
    .req  (req_valid_i),
    .last (last_grant_r),
    .gnt  (pick_gnt),
    .any  (pick_any)
  );

  assign pick_idx = pick_gnt[1];

  // Handshake strobes that must answer in the same cycle as the request.
  // Both are held off while reset is sampled so a dropped transaction
  // never leaks a yumi.
  always_comb begin
    req_yumi_o    = 2'b00;
    mem_resp_take = 1'b0;
    if (!reset) begin
      if (state_r == IDLE) begin
        req_yumi_o = pick_gnt;
      end
      if (state_r == ISSUE) begin
        mem_resp_take = mem_req_yumi_i & mem_resp_valid_i;
      end else if (state_r == WAIT_RESP) begin
        mem_resp_take = mem_resp_valid_i;
      end
    end
  end

  assign mem_resp_yumi_o = mem_resp_take;
  assign mem_valid_o     = (state_r == ISSUE);
  assign mem_addr_o      = addr_r;
  assign mem_wen_o       = wen_r;
  assign mem_byte_o      = byte_r;
  assign mem_wdata_o     = wdata_r;
  assign resp_valid_o    = (state_r == RETURN) ? port_onehot(grant_r) : 2'b00;
  assign resp_data_o     = resp_data_r;
  assign busy_o          = (state_r != IDLE);

  // Arbiter FSM: grant, hold the latched request toward memory, collect the
  // response, then hold it for the granted requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      addr_r       <= '0;
      wen_r        <= 1'b0;
      byte_r       <= 1'b0;
      wdata_r      <= '0;
      resp_data_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_any) begin
            addr_r       <= req_addr_i[pick_idx];
            wen_r        <= req_wen_i[pick_idx];
            byte_r       <= req_byte_i[pick_idx];
            wdata_r      <= req_wdata_i[pick_idx];
            grant_r      <= pick_idx;
            last_grant_r <= pick_idx;
            state_r      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_yumi_i) begin
            if (mem_resp_valid_i) begin
              // Memory accepted and answered in one cycle.
              resp_data_r <= wen_r ? '0 : mem_resp_data_i;
              state_r     <= RETURN;
            end else begin
              state_r     <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (mem_resp_valid_i) begin
            resp_data_r <= wen_r ? '0 : mem_resp_data_i;
            state_r     <= RETURN;
          end
        end
        RETURN: begin
          if (resp_yumi_i[grant_r]) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_dmem_arbiter;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid_i;
  logic [1:0][31:0]  req_addr_i;
  logic [1:0]        req_wen_i;
  logic [1:0]        req_byte_i;
  logic [1:0][31:0]  req_wdata_i;
  logic [1:0]        req_yumi_o;
  logic [1:0]        resp_valid_o;
  logic [31:0]       resp_data_o;
  logic [1:0]        resp_yumi_i;
  logic              mem_valid_o;
  logic [31:0]       mem_addr_o;
  logic              mem_wen_o;
  logic              mem_byte_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_req_yumi_i;
  logic              mem_resp_valid_i;
  logic [31:0]       mem_resp_data_i;
  logic              mem_resp_yumi_o;
  logic              busy_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic              model_last;
  logic [31:0]       ref_mem [logic [31:0]];
  logic [31:0]       mem_arr [logic [31:0]];

  dmem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_i      (req_valid_i),
    .req_addr_i       (req_addr_i),
    .req_wen_i        (req_wen_i),
    .req_byte_i       (req_byte_i),
    .req_wdata_i      (req_wdata_i),
    .req_yumi_o       (req_yumi_o),
    .resp_valid_o     (resp_valid_o),
    .resp_data_o      (resp_data_o),
    .resp_yumi_i      (resp_yumi_i),
    .mem_valid_o      (mem_valid_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wen_o        (mem_wen_o),
    .mem_byte_o       (mem_byte_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_req_yumi_i   (mem_req_yumi_i),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .mem_resp_yumi_o  (mem_resp_yumi_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    req_valid_i      = 2'b00;
    req_addr_i       = '0;
    req_wen_i        = 2'b00;
    req_byte_i       = 2'b00;
    req_wdata_i      = '0;
    resp_yumi_i      = 2'b00;
    mem_req_yumi_i   = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Walks an already-granted transaction through 1-cycle memory and consumes it.
  task automatic finish_txn(input logic p);
    @(negedge clk); drive_idle(); mem_req_yumi_i = 1'b1;
    @(negedge clk); drive_idle(); mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'hA5A5_0000;
    @(negedge clk); drive_idle(); resp_yumi_i[p] = 1'b1;
    @(negedge clk); drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1; req_valid_i = 2'b11; mem_resp_valid_i = 1'b1; resp_yumi_i = 2'b11;
    @(negedge clk); #1;
    tests_run++; if (req_yumi_o !== 2'b00) begin tests_failed++; $display("FAIL reset_req_yumi: got %b expected 00", req_yumi_o); end
    tests_run++; if (mem_resp_yumi_o !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_resp_yumi: got %b expected 0", mem_resp_yumi_o); end
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    tests_run++; if (mem_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_valid: got %b expected 0", mem_valid_o); end
    tests_run++; if (resp_valid_o !== 2'b00) begin tests_failed++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid_o); end
    tests_run++; if (resp_data_o !== 32'h0) begin tests_failed++; $display("FAIL reset_resp_data: got %h expected 0", resp_data_o); end
    tests_run++; if ({mem_addr_o, mem_wen_o, mem_byte_o, mem_wdata_o} !== 66'h0) begin tests_failed++; $display("FAIL reset_mem_fields: got %h/%b/%b/%h expected zeros", mem_addr_o, mem_wen_o, mem_byte_o, mem_wdata_o); end
    @(negedge clk);
    reset = 1'b0; drive_idle(); req_valid_i = 2'b11; #1;
    tests_run++; if (req_yumi_o !== 2'b01) begin tests_failed++; $display("FAIL reset_first_contention: got %b expected 01", req_yumi_o); end
    finish_txn(1'b0);
  endtask

  task automatic test_single_load();
    req_valid_i = 2'b01; req_addr_i[0] = 32'h10; req_wen_i[0] = 1'b0; #1;
    tests_run++; if (req_yumi_o !== 2'b01) begin tests_failed++; $display("FAIL load_req_yumi: got %b expected 01", req_yumi_o); end
    @(negedge clk); drive_idle(); mem_req_yumi_i = 1'b1; #1;
    tests_run++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h10 || mem_wen_o !== 1'b0) begin tests_failed++; $display("FAIL load_issue: got valid=%b addr=%h wen=%b expected 1/00000010/0", mem_valid_o, mem_addr_o, mem_wen_o); end
    tests_run++; if (req_yumi_o !== 2'b00) begin tests_failed++; $display("FAIL load_no_regrant: got %b expected 00", req_yumi_o); end
    @(negedge clk); drive_idle(); mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'hDEADBEEF; #1;
    tests_run++; if (mem_valid_o !== 1'b0 || mem_resp_yumi_o !== 1'b1) begin tests_failed++; $display("FAIL load_wait: got valid=%b resp_yumi=%b expected 0/1", mem_valid_o, mem_resp_yumi_o); end
    @(negedge clk); drive_idle(); resp_yumi_i = 2'b01; #1;
    tests_run++; if (resp_valid_o !== 2'b01 || resp_data_o !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_return: got %b/%h expected 01/deadbeef", resp_valid_o, resp_data_o); end
    @(negedge clk); drive_idle(); #1;
    tests_run++; if (busy_o !== 1'b0 || resp_valid_o !== 2'b00) begin tests_failed++; $display("FAIL load_back_idle: got busy=%b resp_valid=%b expected 0/00", busy_o, resp_valid_o); end
  endtask

  task automatic test_store();
    req_valid_i = 2'b10; req_addr_i[1] = 32'h20; req_wen_i[1] = 1'b1; req_byte_i[1] = 1'b1; req_wdata_i[1] = 32'h55; #1;
    tests_run++; if (req_yumi_o !== 2'b10) begin tests_failed++; $display("FAIL store_req_yumi: got %b expected 10", req_yumi_o); end
    @(negedge clk); drive_idle(); mem_req_yumi_i = 1'b1; #1;
    tests_run++; if (mem_addr_o !== 32'h20 || mem_wen_o !== 1'b1 || mem_byte_o !== 1'b1 || mem_wdata_o !== 32'h55) begin tests_failed++; $display("FAIL store_fields: got %h/%b/%b/%h expected 00000020/1/1/00000055", mem_addr_o, mem_wen_o, mem_byte_o, mem_wdata_o); end
    @(negedge clk); drive_idle(); mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'hFFFF_FFFF; #1;
    tests_run++; if (mem_resp_yumi_o !== 1'b1) begin tests_failed++; $display("FAIL store_mem_resp_yumi: got %b expected 1", mem_resp_yumi_o); end
    @(negedge clk); drive_idle(); resp_yumi_i = 2'b01; #1;
    tests_run++; if (resp_valid_o !== 2'b10 || resp_data_o !== 32'h0) begin tests_failed++; $display("FAIL store_return: got %b/%h expected 10/00000000", resp_valid_o, resp_data_o); end
    @(negedge clk); drive_idle(); resp_yumi_i = 2'b10; #1;
    tests_run++; if (resp_valid_o !== 2'b10) begin tests_failed++; $display("FAIL store_wrong_port_yumi: got %b expected 10", resp_valid_o); end
    @(negedge clk); drive_idle(); #1;
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL store_back_idle: got %b expected 0", busy_o); end
  endtask

  task automatic test_stall();
    req_valid_i = 2'b01; req_addr_i[0] = 32'h44; req_wdata_i[0] = 32'h1234; #1;
    tests_run++; if (req_yumi_o !== 2'b01) begin tests_failed++; $display("FAIL stall_req_yumi: got %b expected 01", req_yumi_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive_idle();
      req_valid_i = 2'b11; req_addr_i[0] = 32'hFFFF_FFF0; req_addr_i[1] = 32'h88;
      mem_req_yumi_i = (i == 3); #1;
      tests_run++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h44 || mem_wen_o !== 1'b0 || mem_wdata_o !== 32'h1234) begin tests_failed++; $display("FAIL stall_hold_%0d: got %b/%h/%b/%h expected 1/00000044/0/00001234", i, mem_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o); end
      tests_run++; if (req_yumi_o !== 2'b00) begin tests_failed++; $display("FAIL stall_no_regrant_%0d: got %b expected 00", i, req_yumi_o); end
    end
    @(negedge clk); drive_idle(); mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'hCAFE;
    @(negedge clk); drive_idle(); resp_yumi_i = 2'b01; #1;
    tests_run++; if (resp_valid_o !== 2'b01 || resp_data_o !== 32'hCAFE) begin tests_failed++; $display("FAIL stall_return: got %b/%h expected 01/0000cafe", resp_valid_o, resp_data_o); end
    @(negedge clk); drive_idle();
  endtask

  task automatic test_same_cycle();
    req_valid_i = 2'b01; req_addr_i[0] = 32'h30; #1;
    tests_run++; if (req_yumi_o !== 2'b01) begin tests_failed++; $display("FAIL same_req_yumi: got %b expected 01", req_yumi_o); end
    @(negedge clk); drive_idle(); mem_req_yumi_i = 1'b1; mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h1234_5678; #1;
    tests_run++; if (mem_valid_o !== 1'b1 || mem_resp_yumi_o !== 1'b1) begin tests_failed++; $display("FAIL same_cycle_yumi: got valid=%b resp_yumi=%b expected 1/1", mem_valid_o, mem_resp_yumi_o); end
    @(negedge clk); drive_idle(); resp_yumi_i = 2'b01; #1;
    tests_run++; if (resp_valid_o !== 2'b01 || resp_data_o !== 32'h1234_5678 || mem_valid_o !== 1'b0) begin tests_failed++; $display("FAIL same_return: got %b/%h/%b expected 01/12345678/0", resp_valid_o, resp_data_o, mem_valid_o); end
    @(negedge clk); drive_idle(); #1;
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL same_back_idle: got %b expected 0", busy_o); end
  endtask

  task automatic test_reset_midflight();
    req_valid_i = 2'b01; req_addr_i[0] = 32'h50;
    @(negedge clk); drive_idle(); mem_req_yumi_i = 1'b1;
    @(negedge clk); drive_idle(); #1;
    tests_run++; if (busy_o !== 1'b1 || mem_valid_o !== 1'b0) begin tests_failed++; $display("FAIL mid_in_wait: got busy=%b valid=%b expected 1/0", busy_o, mem_valid_o); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; drive_idle(); mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'hBAD0_BAD0; #1;
    tests_run++; if (busy_o !== 1'b0 || mem_valid_o !== 1'b0 || resp_valid_o !== 2'b00 || resp_data_o !== 32'h0 || mem_addr_o !== 32'h0) begin tests_failed++; $display("FAIL mid_after_reset: got busy=%b valid=%b rv=%b rd=%h addr=%h expected all zero", busy_o, mem_valid_o, resp_valid_o, resp_data_o, mem_addr_o); end
    tests_run++; if (mem_resp_yumi_o !== 1'b0) begin tests_failed++; $display("FAIL mid_stale_resp_yumi: got %b expected 0", mem_resp_yumi_o); end
    @(negedge clk); drive_idle(); #1;
    tests_run++; if (busy_o !== 1'b0 || resp_valid_o !== 2'b00) begin tests_failed++; $display("FAIL mid_stale_ignored: got busy=%b rv=%b expected 0/00", busy_o, resp_valid_o); end
    req_valid_i = 2'b11; #1;
    tests_run++; if (req_yumi_o !== 2'b01) begin tests_failed++; $display("FAIL mid_contention: got %b expected 01", req_yumi_o); end
    finish_txn(1'b0);
  endtask

  // Random traffic. Requesters hold a request until yumi'd, then wait for and
  // consume the response after a random delay. Memory accepts and answers
  // after random delays. The model tracks the arbiter only at the transaction
  // level: idle/busy, who holds the grant, whether a response is ready.
  task automatic test_random(input int n_txn, input bit both_always);
    logic [1:0]  pend;
    logic [31:0] ra [2];
    logic [31:0] wd [2];
    logic        rw [2];
    logic        rb [2];
    bit          busy_m, resp_rdy, take_resp, mem_take, m_wen;
    logic        gm, g;
    logic [1:0]  exp_yumi, exp_rv;
    logic [31:0] exp_data, ex_addr, ex_wdata, m_data;
    logic        ex_wen, ex_byte;
    int          mphase, mcnt, rc, done, cyc;

    ref_mem.delete(); mem_arr.delete();
    apply_reset();
    model_last = 1'b1;
    pend = 2'b00; busy_m = 0; resp_rdy = 0; gm = 1'b0;
    mphase = 0; mcnt = 0; done = 0; cyc = 0;
    exp_data = '0; ex_addr = '0; ex_wdata = '0; ex_wen = 0; ex_byte = 0; m_data = '0; m_wen = 0;
    for (int p = 0; p < 2; p++) begin ra[p] = '0; wd[p] = '0; rw[p] = 0; rb[p] = 0; end

    while (done < n_txn && cyc < n_txn * 30) begin
      drive_idle();
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && !(busy_m && gm == 1'(p)) && (both_always || $urandom_range(0, 2) == 0)) begin
          ra[p] = 32'($urandom_range(0, 15)) << 2;
          wd[p] = $urandom;
          rw[p] = 1'($urandom_range(0, 1));
          rb[p] = 1'($urandom_range(0, 1));
          pend[p] = 1'b1;
        end
      end
      req_valid_i = pend;
      for (int p = 0; p < 2; p++) begin
        req_addr_i[p] = ra[p]; req_wdata_i[p] = wd[p]; req_wen_i[p] = rw[p]; req_byte_i[p] = rb[p];
      end

      take_resp = resp_rdy && ($urandom_range(0, 1) == 1);
      if (take_resp) resp_yumi_i[gm] = 1'b1;
      resp_yumi_i[!gm] = 1'($urandom_range(0, 1));

      mem_take = 0;
      mem_resp_data_i = $urandom;
      if (mphase == 0 && mem_valid_o === 1'b1) begin
        tests_run++; if (!busy_m) begin tests_failed++; $display("FAIL rnd_mem_valid_ungranted: got mem_valid=1 expected 0"); end
        mphase = 1; mcnt = $urandom_range(0, 3);
      end
      if (mphase == 1) begin
        tests_run++;
        if (mem_valid_o !== 1'b1 || mem_addr_o !== ex_addr || mem_wen_o !== ex_wen || mem_byte_o !== ex_byte || mem_wdata_o !== ex_wdata) begin
          tests_failed++;
          $display("FAIL rnd_issue_fields: got %b/%h/%b/%b/%h expected 1/%h/%b/%b/%h", mem_valid_o, mem_addr_o, mem_wen_o, mem_byte_o, mem_wdata_o, ex_addr, ex_wen, ex_byte, ex_wdata);
        end
        if (mcnt == 0) begin
          mem_req_yumi_i = 1'b1;
          m_wen = mem_wen_o;
          if (mem_wen_o) mem_arr[mem_addr_o] = mem_wdata_o;
          m_data = mem_arr.exists(mem_addr_o) ? mem_arr[mem_addr_o] : 32'h0;
          rc = $urandom_range(0, 2);
          if (rc == 0) begin
            mem_resp_valid_i = 1'b1; mem_resp_data_i = m_wen ? $urandom : m_data;
            mem_take = 1; mphase = 0;
          end else begin
            mphase = 2; mcnt = rc;
          end
        end else begin
          mcnt--;
        end
      end else if (mphase == 2) begin
        tests_run++; if (mem_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rnd_valid_after_accept: got %b expected 0", mem_valid_o); end
        mcnt--;
        if (mcnt == 0) begin
          mem_resp_valid_i = 1'b1; mem_resp_data_i = m_wen ? $urandom : m_data;
          mem_take = 1; mphase = 0;
        end
      end else begin
        mem_resp_valid_i = ($urandom_range(0, 3) == 0);
      end

      #1;
      if (busy_m || pend == 2'b00) exp_yumi = 2'b00;
      else if (pend == 2'b11)      exp_yumi = model_last ? 2'b01 : 2'b10;
      else                         exp_yumi = pend;
      tests_run++; if (req_yumi_o !== exp_yumi) begin tests_failed++; $display("FAIL rnd_req_yumi: cycle %0d got %b expected %b", cyc, req_yumi_o, exp_yumi); end
      tests_run++; if (mem_resp_yumi_o !== mem_take) begin tests_failed++; $display("FAIL rnd_mem_resp_yumi: cycle %0d got %b expected %b", cyc, mem_resp_yumi_o, mem_take); end
      exp_rv = resp_rdy ? (gm ? 2'b10 : 2'b01) : 2'b00;
      tests_run++; if (resp_valid_o !== exp_rv) begin tests_failed++; $display("FAIL rnd_resp_valid: cycle %0d got %b expected %b", cyc, resp_valid_o, exp_rv); end
      if (resp_rdy) begin
        tests_run++; if (resp_data_o !== exp_data) begin tests_failed++; $display("FAIL rnd_resp_data: cycle %0d got %h expected %h", cyc, resp_data_o, exp_data); end
      end
      tests_run++; if (busy_o !== busy_m) begin tests_failed++; $display("FAIL rnd_busy: cycle %0d got %b expected %b", cyc, busy_o, busy_m); end

      @(negedge clk);
      cyc++;
      if (exp_yumi != 2'b00) begin
        g = exp_yumi[1];
        busy_m = 1; gm = g; model_last = g; pend[g] = 1'b0;
        ex_addr = ra[g]; ex_wen = rw[g]; ex_byte = rb[g]; ex_wdata = wd[g];
        if (rw[g]) begin
          exp_data = 32'h0;
          ref_mem[ra[g]] = wd[g];
        end else begin
          exp_data = ref_mem.exists(ra[g]) ? ref_mem[ra[g]] : 32'h0;
        end
      end
      if (mem_take) resp_rdy = 1;
      if (take_resp) begin resp_rdy = 0; busy_m = 0; done++; end
    end

    tests_run++; if (done < n_txn) begin tests_failed++; $display("FAIL rnd_timeout: got %0d transactions expected %0d", done, n_txn); end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    test_reset();
    test_single_load();
    test_store();
    test_stall();
    test_same_cycle();
    test_reset_midflight();
    test_random(24, 1'b1);
    test_random(40, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
